// File: rtl/regfile_writeback_queue.sv
// regfile_writeback_queue: buffers writeback results and drains them one per cycle into the
// register-file write port, exposing pending-write hazards and youngest-value forwarding to decode.
module regfile_writeback_queue #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_W-1:0]            in_addr,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         wb_stall,
    output logic                         regWrite,
    output logic [ADDR_W-1:0]            address,
    output logic [DATA_W-1:0]            data,
    input  logic [ADDR_W-1:0]            query_reg1,
    input  logic [ADDR_W-1:0]            query_reg2,
    output logic                         hazard1,
    output logic                         hazard2,
    output logic [DATA_W-1:0]            fwd_data1,
    output logic [DATA_W-1:0]            fwd_data2,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    output logic                         full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [ADDR_W-1:0]            mem_addr [DEPTH];
    logic [DATA_W-1:0]            mem_data [DEPTH];
    logic [CW-1:0]                wr_ptr;
    logic [CW-1:0]                rd_ptr;
    logic                         push;
    logic                         drain;
    logic [1:0][ADDR_W-1:0]       qry;
    logic [1:0]                   hit;
    logic [1:0][DATA_W-1:0]       fwd;

    // pointers carry one wrap bit beyond the index so full and empty are distinguishable
    assign count    = wr_ptr - rd_ptr;
    assign empty    = count == '0;
    assign full     = count == CW'(DEPTH);
    assign in_ready = !full;
    assign push     = in_valid && in_ready && in_addr != '0;
    assign drain    = !wb_stall && !empty;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_addr[wr_ptr[AW-1:0]] <= in_addr;
            mem_data[wr_ptr[AW-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            regWrite <= 1'b0;
            address  <= '0;
            data     <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + CW'(1);
            if (drain) rd_ptr <= rd_ptr + CW'(1);
            regWrite <= drain;
            if (drain) begin
                address <= mem_addr[rd_ptr[AW-1:0]];
                data    <= mem_data[rd_ptr[AW-1:0]];
            end
        end
    end

    assign qry[0] = query_reg1;
    assign qry[1] = query_reg2;

    // scan oldest to youngest so the youngest matching entry overrides the output stage
    always_comb begin
        hit = '0;
        fwd = '0;
        for (int p = 0; p < 2; p++) begin
            if (regWrite && address == qry[p]) begin
                hit[p] = 1'b1;
                fwd[p] = data;
            end
            for (int k = 0; k < DEPTH; k++) begin
                if (CW'(k) < count && mem_addr[rd_ptr[AW-1:0] + AW'(k)] == qry[p]) begin
                    hit[p] = 1'b1;
                    fwd[p] = mem_data[rd_ptr[AW-1:0] + AW'(k)];
                end
            end
            if (qry[p] == '0) begin
                hit[p] = 1'b0;
                fwd[p] = '0;
            end
        end
    end

    assign hazard1   = hit[0];
    assign hazard2   = hit[1];
    assign fwd_data1 = fwd[0];
    assign fwd_data2 = fwd[1];
endmodule
